// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types for the I2C transaction arbiter: command bundle,
// FSM state encoding and the watchdog length helper.
package i2c_txn_arbiter_pkg;

    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam int   I2C_ADDR_W   = 7;
    localparam int   I2C_DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    typedef struct packed {
        logic                  rw;
        logic [I2C_ADDR_W-1:0] dev_addr;
        logic [I2C_DATA_W-1:0] reg_addr;
        logic [I2C_DATA_W-1:0] wdata;
    } i2c_cmd_t;

    function automatic int to_cycles(
        input int clk_freq,
        input int timeout_us
    );
        return clk_freq / 1_000_000 * timeout_us;
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and master-side signals of the I2C transaction arbiter.
// The arbiter uses the slave view; the surrounding system drives the master view.
interface i2c_txn_arbiter_if
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_rw;
    logic [I2C_ADDR_W*NUM_REQ-1:0] req_dev_addr;
    logic [I2C_DATA_W*NUM_REQ-1:0] req_reg_addr;
    logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata;

    logic [NUM_REQ-1:0]            rsp_valid;
    logic [I2C_DATA_W-1:0]         rsp_rdata;
    logic                          rsp_nack;
    logic                          rsp_timeout;

    logic                          m_cmd_valid;
    logic                          m_cmd_ready;
    logic                          m_cmd_rw;
    logic [I2C_ADDR_W-1:0]         m_dev_addr;
    logic [I2C_DATA_W-1:0]         m_reg_addr;
    logic [I2C_DATA_W-1:0]         m_wdata;
    logic                          m_done;
    logic [I2C_DATA_W-1:0]         m_rdata;
    logic                          m_nack;
    logic                          m_abort;

    logic                          busy;

    modport slave (
        input  req_valid,
        input  req_rw,
        input  req_dev_addr,
        input  req_reg_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_nack,
        output rsp_timeout,
        output m_cmd_valid,
        input  m_cmd_ready,
        output m_cmd_rw,
        output m_dev_addr,
        output m_reg_addr,
        output m_wdata,
        input  m_done,
        input  m_rdata,
        input  m_nack,
        output m_abort,
        output busy
    );

    modport master (
        output req_valid,
        output req_rw,
        output req_dev_addr,
        output req_reg_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_nack,
        input  rsp_timeout,
        input  m_cmd_valid,
        output m_cmd_ready,
        input  m_cmd_rw,
        input  m_dev_addr,
        input  m_reg_addr,
        input  m_wdata,
        output m_done,
        output m_rdata,
        output m_nack,
        input  m_abort,
        input  busy
    );

endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int pos;

    // Scan farthest-first so the nearest request to ptr overwrites last.
    always_comb begin
        gnt = '0;
        idx = '0;
        pos = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one register-level I2C master among NUM_REQ requesters with
// round-robin grants, one transaction in flight and a per-transaction watchdog.
module i2c_txn_arbiter
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic             clk,
    input  logic             rst,
    i2c_txn_arbiter_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TO_CYC = to_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int WD_W   = $clog2(TO_CYC) + 1;

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e state_q;
    arb_state_e state_d;

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      win_q;
    logic [IDX_W-1:0]      arb_idx;
    logic [NUM_REQ-1:0]    win_oh_q;
    logic [NUM_REQ-1:0]    arb_gnt;

    i2c_cmd_t              cmd_q;
    i2c_cmd_t              sel_cmd;

    logic [WD_W-1:0]       wdog_q;
    logic                  wd_hit;
    logic                  expire;

    logic [I2C_DATA_W-1:0] rdata_q;
    logic                  nack_q;
    logic                  timeout_q;
    logic                  abort_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        sel_cmd.rw       = bus.req_rw[win_q];
        sel_cmd.dev_addr = bus.req_dev_addr[win_q * I2C_ADDR_W +: I2C_ADDR_W];
        sel_cmd.reg_addr = bus.req_reg_addr[win_q * I2C_DATA_W +: I2C_DATA_W];
        sel_cmd.wdata    = bus.req_wdata[win_q * I2C_DATA_W +: I2C_DATA_W];
    end

    assign wd_hit = (wdog_q == WD_LAST);

    // A completion on the expiry cycle wins over the abort.
    always_comb begin
        state_d = state_q;
        expire  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (wd_hit) begin
                    expire  = 1'b1;
                    state_d = ST_RESP;
                end else if (bus.m_cmd_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.m_done) begin
                    state_d = ST_RESP;
                end else if (wd_hit) begin
                    expire  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            win_q     <= '0;
            win_oh_q  <= '0;
            cmd_q     <= '0;
            wdog_q    <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= expire;

            // Watchdog starts counting on the edge that leaves GRANT.
            if (state_q == ST_IDLE) begin
                win_q    <= arb_idx;
                win_oh_q <= arb_gnt;
                wdog_q   <= '0;
            end else if (wdog_q != '1) begin
                wdog_q <= wdog_q + 1'b1;
            end

            if (state_q == ST_GRANT) begin
                cmd_q <= sel_cmd;
                ptr_q <= (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
            end

            if (state_q == ST_WAIT && bus.m_done) begin
                rdata_q   <= bus.m_rdata;
                nack_q    <= bus.m_nack;
                timeout_q <= 1'b0;
            end else if (expire) begin
                rdata_q   <= '0;
                nack_q    <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = (state_q == ST_GRANT) ? win_oh_q : '0;
    assign bus.rsp_valid   = (state_q == ST_RESP)  ? win_oh_q : '0;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_nack    = nack_q;
    assign bus.rsp_timeout = timeout_q;

    assign bus.m_cmd_valid = (state_q == ST_ISSUE);
    assign bus.m_cmd_rw    = cmd_q.rw;
    assign bus.m_dev_addr  = cmd_q.dev_addr;
    assign bus.m_reg_addr  = cmd_q.reg_addr;
    assign bus.m_wdata     = cmd_q.wdata;
    assign bus.m_abort     = abort_q;

    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: requesters and a scripted I2C master,
// with command/response scoreboards filled as stimulus is driven.
module tb_i2c_txn_arbiter;
    import i2c_txn_arbiter_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    i2c_txn_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_txn_arbiter #(
        .NUM_REQ    (N),
        .CLK_FREQ   (50_000_000),
        .TIMEOUT_US (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] ra;
        logic [7:0] wd;
    } cmd_t;

    typedef struct packed {
        logic [N-1:0] owner;
        logic [7:0]   rdata;
        logic         nack;
        logic         to;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
        bus.req_rw[i]             = rw;
        bus.req_dev_addr[i*7 +: 7] = dev;
        bus.req_reg_addr[i*8 +: 8] = ra;
        bus.req_wdata[i*8 +: 8]    = wd;
        bus.req_valid[i]          = 1'b1;
    endtask

    task automatic exp_cmd(input logic rw, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
        cmd_q.push_back('{rw, dev, ra, wd});
    endtask

    task automatic exp_rsp(input int i, input logic [7:0] rd,
                           input logic nk, input logic to);
        logic [N-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        rsp_q.push_back('{oh, rd, nk, to});
    endtask

    task automatic wait_grant(input int i, output int unsigned gc);
        int n;
        logic [N-1:0] oh;
        n = 0;
        oh = '0;
        oh[i] = 1'b1;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_onehot", bus.req_ready, oh);
        gc = cyc_cnt;
    endtask

    task automatic accept();
        int n;
        int sz;
        cmd_t e;
        n = 0;
        while (!bus.m_cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_valid_seen", bus.m_cmd_valid, 1);
        sz = cmd_q.size();
        chk("cmd_sb_nonempty", sz != 0, 1);
        e = '0;
        if (sz != 0) e = cmd_q.pop_front();
        chk("cmd_fields",
            {bus.m_cmd_rw, bus.m_dev_addr, bus.m_reg_addr, bus.m_wdata}, e);
        bus.m_cmd_ready = 1'b1;
        @(negedge clk);
        bus.m_cmd_ready = 1'b0;
    endtask

    task automatic done(input logic [7:0] rd, input logic nk);
        bus.m_rdata = rd;
        bus.m_nack  = nk;
        bus.m_done  = 1'b1;
        @(negedge clk);
        bus.m_done  = 1'b0;
        bus.m_rdata = '0;
        bus.m_nack  = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        int sz;
        rsp_t e;
        n = 0;
        while (bus.rsp_valid == '0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", bus.rsp_valid != '0, 1);
        sz = rsp_q.size();
        chk("rsp_sb_nonempty", sz != 0, 1);
        e = '0;
        if (sz != 0) e = rsp_q.pop_front();
        chk("rsp_fields", {bus.rsp_valid, bus.rsp_rdata,
                           bus.rsp_nack, bus.rsp_timeout}, e);
        chk("abort_with_rsp", bus.m_abort, e.to);
        chk("busy_in_resp", bus.busy, 1);
    endtask

    task automatic pulse_end();
        @(negedge clk);
        chk("rsp_one_cycle", {bus.rsp_valid, bus.m_abort}, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned g;
        int unsigned c0;
        int          n;
        logic        any_ready;
        logic        any_abort;

        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_rw       = '0;
        bus.req_dev_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_wdata    = '0;
        bus.m_cmd_ready  = 1'b0;
        bus.m_done       = 1'b0;
        bus.m_rdata      = '0;
        bus.m_nack       = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ctrl", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata,
                         bus.rsp_nack, bus.rsp_timeout, bus.m_cmd_valid,
                         bus.m_abort, bus.busy}, 0);
        chk("rst_cmd", {bus.m_cmd_rw, bus.m_dev_addr,
                        bus.m_reg_addr, bus.m_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Stray completion while idle.
        bus.m_done  = 1'b1;
        bus.m_rdata = 8'hFF;
        @(negedge clk);
        chk("stray_done", {bus.rsp_valid, bus.busy}, 0);
        bus.m_done  = 1'b0;
        bus.m_rdata = '0;
        @(negedge clk);

        // Single write from requester 0; fields scrambled after accept.
        set_req(0, I2C_RW_WRITE, 7'h74, 8'h01, 8'h5A);
        exp_cmd(I2C_RW_WRITE, 7'h74, 8'h01, 8'h5A);
        exp_rsp(0, 8'h00, 1'b0, 1'b0);
        c0 = cyc_cnt;
        wait_grant(0, g);
        chk("req_accept_edges", g + 1 - c0, 2);
        @(negedge clk);
        bus.req_valid[0]       = 1'b0;
        bus.req_dev_addr[6:0]  = 7'h00;
        bus.req_wdata[7:0]     = 8'hFF;
        accept();
        done(8'h00, 1'b0);
        wait_rsp(5, n);
        chk("done_to_rsp", n, 0);
        pulse_end();
        chk("busy_drop", bus.busy, 0);

        // Read from requester 2.
        set_req(2, I2C_RW_READ, 7'h50, 8'h10, 8'h00);
        exp_cmd(I2C_RW_READ, 7'h50, 8'h10, 8'h00);
        exp_rsp(2, 8'hC3, 1'b0, 1'b0);
        wait_grant(2, g);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        accept();
        repeat (3) @(negedge clk);
        done(8'hC3, 1'b0);
        wait_rsp(5, n);
        chk("read_done_to_rsp", n, 0);
        pulse_end();

        // Watchdog expiry: master never completes.
        set_req(1, I2C_RW_WRITE, 7'h20, 8'hA0, 8'h11);
        exp_cmd(I2C_RW_WRITE, 7'h20, 8'hA0, 8'h11);
        exp_rsp(1, 8'h00, 1'b0, 1'b1);
        wait_grant(1, g);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        accept();
        wait_rsp(1100, n);
        chk("abort_cycle", cyc_cnt - g, 1000);
        pulse_end();
        chk("cmd_valid_after_abort", bus.m_cmd_valid, 0);

        // Completion on the expiry cycle, plus a request withdrawn before grant.
        set_req(3, I2C_RW_WRITE, 7'h22, 8'h33, 8'h44);
        exp_cmd(I2C_RW_WRITE, 7'h22, 8'h33, 8'h44);
        exp_rsp(3, 8'h3C, 1'b1, 1'b0);
        wait_grant(3, g);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        accept();
        set_req(2, I2C_RW_WRITE, 7'h11, 8'h22, 8'h33);
        repeat (5) @(negedge clk);
        bus.req_valid[2] = 1'b0;
        repeat (int'(g + 999 - cyc_cnt)) @(negedge clk);
        done(8'h3C, 1'b1);
        wait_rsp(5, n);
        chk("collision_done_to_rsp", n, 0);
        any_ready = 1'b0;
        any_abort = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_ready |= |bus.req_ready;
            any_abort |= bus.m_abort;
        end
        chk("withdrawn_req_skipped", {any_ready, any_abort, bus.busy}, 0);

        // Fairness: all four held valid for eight transactions.
        for (int i = 0; i < N; i++)
            set_req(i, i[0], 7'(8'h40 + i), 8'(8'h80 + i), 8'(8'h60 + i));
        for (int k = 0; k < 8; k++) begin
            exp_cmd(k[0], 7'(8'h40 + k % N), 8'(8'h80 + k % N),
                    8'(8'h60 + k % N));
            exp_rsp(k % N, 8'(8'h10 + k), k[0], 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            wait_grant(k % N, g);
            @(negedge clk);
            if (k == 7) bus.req_valid = '0;
            accept();
            done(8'(8'h10 + k), k[0]);
            wait_rsp(5, n);
            pulse_end();
        end

        // Reset while waiting on the master.
        set_req(2, I2C_RW_WRITE, 7'h5B, 8'hC4, 8'h9D);
        exp_cmd(I2C_RW_WRITE, 7'h5B, 8'hC4, 8'h9D);
        wait_grant(2, g);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        accept();
        repeat (3) @(negedge clk);
        chk("busy_in_wait", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata,
                            bus.rsp_nack, bus.rsp_timeout, bus.m_cmd_valid,
                            bus.m_abort, bus.busy}, 0);
        chk("midrst_cmd", {bus.m_cmd_rw, bus.m_dev_addr,
                           bus.m_reg_addr, bus.m_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_quiet", {bus.rsp_valid, bus.m_abort}, 0);

        // Pointer restarts at 0, so requester 1 beats requester 3.
        set_req(1, I2C_RW_READ, 7'h31, 8'h41, 8'h00);
        set_req(3, I2C_RW_WRITE, 7'h33, 8'h43, 8'hE7);
        exp_cmd(I2C_RW_READ, 7'h31, 8'h41, 8'h00);
        exp_rsp(1, 8'h96, 1'b0, 1'b0);
        exp_cmd(I2C_RW_WRITE, 7'h33, 8'h43, 8'hE7);
        exp_rsp(3, 8'h00, 1'b1, 1'b0);
        wait_grant(1, g);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        accept();
        done(8'h96, 1'b0);
        wait_rsp(5, n);
        pulse_end();
        wait_grant(3, g);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        accept();
        done(8'h00, 1'b1);
        wait_rsp(5, n);
        pulse_end();

        chk("scoreboards_drained", cmd_q.size() + rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
